kdf_key_checker: RTL and testbench

//  Consumer/controller for the iterated-hash KDF core: accepts a password-check request, drives the KDF

---
 rtl/kdf_key_checker.sv | 172 +++++++++++++++++
 tb/tb_kdf_key_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kdf_key_checker.sv
// Password-check controller around one iterated-hash KDF core: runs the KDF, compares the
// derived key to a stored reference, and enforces a failed-attempt lockout and a run timeout.
`timescale 1ns/1ps
module kdf_key_checker #(
  parameter int N              = 128,
  parameter int SALT_WIDTH     = 64,
  parameter int COUNT_WIDTH    = 32,
  parameter int PSW_WIDTH      = 32,
  parameter int RST_CYCLES     = 2,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PSW_WIDTH-1:0]   req_password,
  input  logic [SALT_WIDTH-1:0]  cfg_salt,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic [N-1:0]           ref_key,
  output logic                   resp_valid,
  output logic                   resp_match,
  output logic                   resp_error,
  output logic                   locked,
  output logic                   kdf_rst,
  output logic [SALT_WIDTH-1:0]  kdf_salt,
  output logic [COUNT_WIDTH-1:0] kdf_count,
  output logic [PSW_WIDTH-1:0]   kdf_password,
  input  logic                   kdf_end,
  input  logic [N-1:0]           kdf_key,
  output logic [2:0]             dbg_state
);

  // Request handshake: a request is taken on a rising clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one check is ever in flight.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_KRST = 3'd1, S_RUN = 3'd2, S_CMP = 3'd3, S_RESP = 3'd4, S_LOCK = 3'd5
  } state_t;

  localparam int TMAX0 = (RST_CYCLES > LOCKOUT_CYCLES) ? RST_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int FW    = $clog2(MAX_ATTEMPTS + 1);

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [FW-1:0]        r_fail_cnt;
  logic [PSW_WIDTH-1:0] r_pw;
  logic [N-1:0]         r_key;
  logic                 r_ready;
  logic                 r_resp_valid;
  logic                 r_resp_match;
  logic                 r_resp_error;
  logic                 r_locked;
  logic                 r_kdf_rst;

  logic                 w_accept;
  logic [FW-1:0]        w_fail_next;

  assign w_accept = req_valid & r_ready;

  // Fail counter after the current response: a match clears it, anything else saturates upward.
  assign w_fail_next = r_resp_match ? '0 :
                       (r_fail_cnt == FW'(MAX_ATTEMPTS)) ? r_fail_cnt : r_fail_cnt + FW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_fail_cnt   <= '0;
      r_pw         <= '0;
      r_key        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_match <= 1'b0;
      r_resp_error <= 1'b0;
      r_locked     <= 1'b0;
      r_kdf_rst    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pw    <= req_password;
            r_ready <= 1'b0;
            r_timer <= '0;
            if (cfg_count == '0) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_match <= 1'b0;
              r_resp_error <= 1'b1;
            end else begin
              r_state <= S_KRST;
            end
          end
        end
        S_KRST: begin
          if (r_timer == TW'(RST_CYCLES - 1)) begin
            r_state   <= S_RUN;
            r_timer   <= '0;
            r_kdf_rst <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RUN: begin
          // kdf_end takes priority over a timeout landing on the same cycle.
          if (kdf_end) begin
            r_key     <= kdf_key;
            r_state   <= S_CMP;
            r_kdf_rst <= 1'b1;
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state      <= S_RESP;
            r_kdf_rst    <= 1'b1;
            r_resp_valid <= 1'b1;
            r_resp_match <= 1'b0;
            r_resp_error <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CMP: begin
          // XOR-reduce keeps the compare a fixed full-width operation.
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_match <= ~|(r_key ^ ref_key);
          r_resp_error <= 1'b0;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_fail_cnt   <= w_fail_next;
          r_key        <= '0;
          r_pw         <= '0;
          r_timer      <= '0;
          if (w_fail_next == FW'(MAX_ATTEMPTS)) begin
            r_state  <= S_LOCK;
            r_locked <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_LOCK: begin
          if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            r_locked   <= 1'b0;
            r_ready    <= 1'b1;
            r_fail_cnt <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_match   = r_resp_match;
  assign resp_error   = r_resp_error;
  assign locked       = r_locked;
  assign kdf_rst      = r_kdf_rst;
  assign kdf_salt     = cfg_salt;
  assign kdf_count    = cfg_count;
  assign kdf_password = r_pw;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_kdf_key_checker.sv
// Bench for kdf_key_checker: a behavioural KDF stub, table-driven request vectors with a
// response scoreboard, and hand-written lockout and mid-run reset sequences.
`timescale 1ns/1ps
module tb_kdf_key_checker;

  localparam int N = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_password;
  logic [63:0]   cfg_salt;
  logic [31:0]   cfg_count;
  logic [N-1:0]  ref_key;
  logic          resp_valid, resp_match, resp_error, locked, kdf_rst;
  logic [63:0]   kdf_salt;
  logic [31:0]   kdf_count;
  logic [31:0]   kdf_password;
  logic          kdf_end;
  logic [N-1:0]  kdf_key;
  logic [2:0]    dbg_state;

  kdf_key_checker #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_password(req_password), .cfg_salt(cfg_salt), .cfg_count(cfg_count),
    .ref_key(ref_key), .resp_valid(resp_valid), .resp_match(resp_match),
    .resp_error(resp_error), .locked(locked), .kdf_rst(kdf_rst), .kdf_salt(kdf_salt),
    .kdf_count(kdf_count), .kdf_password(kdf_password), .kdf_end(kdf_end),
    .kdf_key(kdf_key), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- KDF stub ----------------
  function automatic logic [N-1:0] key_of(input logic [31:0] pw, input logic [63:0] salt,
                                           input logic [31:0] count);
    return {pw, salt, pw ^ count};
  endfunction

  int stub_delay = 4;  // RUN cycle index at which kdf_end appears; 0 = never
  int s_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt   <= 0;
      kdf_end <= 1'b0;
    end else if (kdf_rst) begin
      s_cnt   <= 0;
      kdf_end <= 1'b0;
    end else if (!kdf_end) begin
      s_cnt <= s_cnt + 1;
      if (stub_delay != 0 && s_cnt + 1 == stub_delay) kdf_end <= 1'b1;
    end
  end
  assign kdf_key = kdf_end ? key_of(kdf_password, kdf_salt, kdf_count) : '1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int   acc_cyc, run_cyc, e_cyc, r_cyc;
  logic kdf_low_seen;
  logic prev_end = 1'b0;
  logic prev_krst = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (!kdf_rst) kdf_low_seen = 1'b1;
      if (kdf_end && !prev_end) e_cyc = cyc;
      if (!kdf_rst && prev_krst) run_cyc = cyc;
      if (resp_valid) begin
        r_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {126'd0, resp_match, resp_error}, 128'h3fff);
        end else begin
          chk("resp_match_error", {126'd0, resp_match, resp_error}, {126'd0, exp_q.pop_front()});
        end
      end
    end
    prev_end  = kdf_end;
    prev_krst = kdf_rst;
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [31:0] pw, input logic [31:0] count, input int delay,
                        input logic exp_match, input logic exp_err);
    int i;
    stub_delay = delay;
    cfg_count  = count;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!req_ready && i < 3000);
    chk("req_ready_wait", {127'd0, req_ready}, 128'd1);
    req_password = pw;
    req_valid    = 1'b1;
    acc_cyc      = cyc;
    kdf_low_seen = 1'b0;
    exp_q.push_back({exp_match, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("resp_seen", {127'd0, exp_q.size() == 0}, 128'd1);
    exp_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] pw;
    logic [31:0] ref_pw;
    logic [63:0] salt;
    logic [31:0] count;
    int          delay;
    logic        exp_match;
    logic        exp_err;
  } vec_t;

  localparam logic [31:0] PW_OK  = 32'hDEADBEEF;
  localparam logic [31:0] PW_BAD = 32'hDEADBEEE;
  localparam logic [63:0] SALT0  = 64'h0123456789ABCDEF;

  vec_t vecs[10];

  initial begin
    logic [31:0] rpw;
    int lock_len, ready_hi;

    rpw = $urandom();
    vecs[0] = '{PW_OK,  PW_OK, SALT0, 32'd4, 4,  1'b1, 1'b0};
    vecs[1] = '{PW_BAD, PW_OK, SALT0, 32'd4, 4,  1'b0, 1'b0};
    vecs[2] = '{PW_BAD, PW_OK, SALT0, 32'd4, 5,  1'b0, 1'b0};
    vecs[3] = '{PW_OK,  PW_OK, SALT0, 32'd4, 3,  1'b1, 1'b0};
    vecs[4] = '{PW_BAD, PW_OK, SALT0, 32'd4, 4,  1'b0, 1'b0};
    vecs[5] = '{32'h0,  PW_OK, SALT0, 32'd4, 1,  1'b0, 1'b0};
    vecs[6] = '{PW_OK,  PW_OK, SALT0, 32'd4, 15, 1'b1, 1'b0};
    vecs[7] = '{PW_OK,  PW_OK, SALT0, 32'd4, 0,  1'b0, 1'b1};
    vecs[8] = '{PW_OK,  PW_OK, SALT0, 32'd0, 4,  1'b0, 1'b1};
    vecs[9] = '{rpw, rpw, {$urandom(), $urandom()}, 32'd7, int'($urandom_range(1, 14)), 1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_password = '0;
    cfg_salt = SALT0; cfg_count = 32'd4; ref_key = key_of(PW_OK, SALT0, 32'd4);
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {127'd0, req_ready},  128'd1);
    chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
    chk("rst_resp_match", {127'd0, resp_match}, 128'd0);
    chk("rst_resp_error", {127'd0, resp_error}, 128'd0);
    chk("rst_locked",     {127'd0, locked},     128'd0);
    chk("rst_kdf_rst",    {127'd0, kdf_rst},    128'd1);
    chk("rst_kdf_pw",     {96'd0, kdf_password}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      cfg_salt = vecs[k].salt;
      ref_key  = key_of(vecs[k].ref_pw, vecs[k].salt, vecs[k].count);
      do_req(vecs[k].pw, vecs[k].count, vecs[k].delay, vecs[k].exp_match, vecs[k].exp_err);
      wait_resp();
      if (vecs[k].count == 0) begin
        chk("cnt0_latency", 128'(r_cyc - acc_cyc), 128'd1);
        chk("cnt0_kdf_rst_held", {127'd0, kdf_low_seen}, 128'd0);
      end else if (vecs[k].delay == 0) begin
        chk("timeout_run_cycles", 128'(r_cyc - run_cyc), 128'd16);
      end else begin
        chk("run_start_latency", 128'(run_cyc - acc_cyc), 128'd3);
        chk("end_to_resp", 128'(r_cyc - e_cyc), 128'd2);
      end
      repeat (2) @(negedge clk);
      chk("idle_locked", {127'd0, locked}, 128'd0);
      chk("idle_ready",  {127'd0, req_ready}, 128'd1);
      chk("idle_pw_zero", {96'd0, kdf_password}, 128'd0);
    end

    // Three consecutive failures -> lockout of exactly 1024 cycles.
    cfg_salt = SALT0;
    ref_key  = key_of(PW_OK, SALT0, 32'd4);
    for (int j = 0; j < 3; j++) begin
      do_req(PW_BAD, 32'd4, 4, 1'b0, 1'b0);
      wait_resp();
    end
    for (int i = 0; i < 50 && !locked; i++) @(negedge clk);
    chk("lock_entered", {127'd0, locked}, 128'd1);
    lock_len = 0; ready_hi = 0;
    while (locked && lock_len < 3000) begin
      if (req_ready) ready_hi++;
      lock_len++;
      @(negedge clk);
    end
    chk("lock_length", 128'(lock_len), 128'd1024);
    chk("lock_ready_low", 128'(ready_hi), 128'd0);
    chk("post_lock_ready", {127'd0, req_ready}, 128'd1);
    do_req(PW_OK, 32'd4, 4, 1'b1, 1'b0);
    wait_resp();

    // Asynchronous reset in RUN aborts silently; next request is served normally.
    do_req(PW_OK, 32'd4, 10, 1'b1, 1'b0);
    for (int i = 0; i < 50 && kdf_rst; i++) @(negedge clk);
    chk("reached_run", {127'd0, kdf_rst}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready",   {127'd0, req_ready},  128'd1);
    chk("mid_rst_valid",   {127'd0, resp_valid}, 128'd0);
    chk("mid_rst_kdf_rst", {127'd0, kdf_rst},    128'd1);
    chk("mid_rst_locked",  {127'd0, locked},     128'd0);
    chk("mid_rst_pw",      {96'd0, kdf_password}, 128'd0);
    chk("mid_rst_state",   {125'd0, dbg_state},  128'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    do_req(PW_OK, 32'd4, 4, 1'b1, 1'b0);
    wait_resp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
